// File: rtl/lcd_cmd_engine.sv
// lcd_cmd_engine
//   Hardware HD44780 driver that sits behind the CPU's memory-mapped LCD
//   register. It runs the power-on wait and init sequence on its own, then
//   turns every REQ toggle into one timed write cycle (setup, EN pulse, hold,
//   execution wait). One further request can wait in a pending slot; any
//   request beyond that is dropped and flagged as overflow.
//
// Ports
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_lcd_reg     LSU register: [31] ON, [30] REQ toggle, [29] OVF_CLR,
//                 [9] RS, [7:0] DATA
//   o_lcd_status  [0] busy, [1] pending, [2] init_done, [3] overflow,
//                 [15:8] done_cnt, all other bits 0
//   o_lcd_on      i_lcd_reg[31] delayed by one cycle
//   o_lcd_en      LCD enable strobe
//   o_lcd_rs      LCD register select
//   o_lcd_rw      tied 0, the controller only writes
//   o_lcd_data    LCD data bus
module lcd_cmd_engine #(
  parameter int unsigned T_POR       = 750000,
  parameter int unsigned T_SETUP     = 4,
  parameter int unsigned T_PULSE     = 25,
  parameter int unsigned T_HOLD      = 4,
  parameter int unsigned T_EXEC      = 2500,
  parameter int unsigned T_EXEC_LONG = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_lcd_reg,
  output logic [31:0] o_lcd_status,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data
);

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned T_MAX = max_u(max_u(max_u(T_POR, T_SETUP), max_u(T_PULSE, T_HOLD)),
                                        max_u(T_EXEC, T_EXEC_LONG));
  localparam int unsigned TW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    POR_WAIT,
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } state_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d, timer_lim;
  logic [1:0]      init_idx_q, init_idx_d;
  logic            init_done_q, init_done_d;
  logic            tog_q;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_rs_q, pend_rs_d;
  logic [7:0]      pend_data_q, pend_data_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      done_cnt_q, done_cnt_d;
  logic            cmd_rs_q, cmd_rs_d;
  logic [7:0]      cmd_data_q, cmd_data_d;
  logic            en_q;
  logic            on_q;
  logic            busy_q;

  logic            evt;
  logic            evt_taken;
  logic            slot_free;
  logic            ovf_set;
  logic            timer_done;
  logic            long_cmd;

  logic            unused_bits;
  assign unused_bits = ^{i_lcd_reg[28:10], i_lcd_reg[8]};

  assign evt      = i_lcd_reg[30] ^ tog_q;
  assign long_cmd = !cmd_rs_q && (cmd_data_q == 8'h01 || cmd_data_q == 8'h02 ||
                                  cmd_data_q == 8'h03);

  // The per-state timer counts up from 0 after entry and expires on the
  // state's last cycle, so a state lasts exactly its T_* cycles and the
  // reset value 0 is already the correct start of the power-on wait.
  always_comb begin
    timer_lim = '0;
    case (state_q)
      POR_WAIT: timer_lim = TW'(T_POR - 1);
      SETUP:    timer_lim = TW'(T_SETUP - 1);
      PULSE:    timer_lim = TW'(T_PULSE - 1);
      HOLD:     timer_lim = TW'(T_HOLD - 1);
      EXEC:     timer_lim = long_cmd ? TW'(T_EXEC_LONG - 1) : TW'(T_EXEC - 1);
      default:  timer_lim = '0;
    endcase
  end

  assign timer_done = (timer_q == timer_lim);

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    init_done_d  = init_done_q;
    pend_valid_d = pend_valid_q;
    pend_rs_d    = pend_rs_q;
    pend_data_d  = pend_data_q;
    done_cnt_d   = done_cnt_q;
    cmd_rs_d     = cmd_rs_q;
    cmd_data_d   = cmd_data_q;
    evt_taken    = 1'b0;
    slot_free    = !pend_valid_q;
    ovf_set      = 1'b0;

    case (state_q)
      POR_WAIT: begin
        if (timer_done) begin
          state_d    = SETUP;
          cmd_rs_d   = 1'b0;
          cmd_data_d = init_cmd(2'd0);
        end
      end
      IDLE: begin
        if (evt) begin
          state_d    = SETUP;
          cmd_rs_d   = i_lcd_reg[9];
          cmd_data_d = i_lcd_reg[7:0];
          evt_taken  = 1'b1;
        end
      end
      SETUP: if (timer_done) state_d = PULSE;
      PULSE: if (timer_done) state_d = HOLD;
      HOLD:  if (timer_done) state_d = EXEC;
      EXEC: begin
        if (timer_done) begin
          if (!init_done_q && init_idx_q != 2'd3) begin
            state_d    = SETUP;
            init_idx_d = init_idx_q + 2'd1;
            cmd_rs_d   = 1'b0;
            cmd_data_d = init_cmd(init_idx_q + 2'd1);
          end else begin
            if (init_done_q) done_cnt_d = done_cnt_q + 8'd1;
            init_done_d = 1'b1;
            // Chain straight into the next command with no idle cycle.
            if (pend_valid_q) begin
              state_d      = SETUP;
              cmd_rs_d     = pend_rs_q;
              cmd_data_d   = pend_data_q;
              pend_valid_d = 1'b0;
              slot_free    = 1'b1;
            end else if (evt) begin
              state_d    = SETUP;
              cmd_rs_d   = i_lcd_reg[9];
              cmd_data_d = i_lcd_reg[7:0];
              evt_taken  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = POR_WAIT;
    endcase

    if (evt && !evt_taken) begin
      if (slot_free) begin
        pend_valid_d = 1'b1;
        pend_rs_d    = i_lcd_reg[9];
        pend_data_d  = i_lcd_reg[7:0];
      end else begin
        ovf_set = 1'b1;
      end
    end

    // A drop in the same cycle as OVF_CLR keeps overflow set.
    ovf_d = ovf_set ? 1'b1 : (i_lcd_reg[29] ? 1'b0 : ovf_q);

    timer_d = (state_d != state_q || state_q == IDLE) ? '0 : timer_q + TW'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= POR_WAIT;
      timer_q      <= '0;
      init_idx_q   <= '0;
      init_done_q  <= 1'b0;
      tog_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_rs_q    <= 1'b0;
      pend_data_q  <= '0;
      ovf_q        <= 1'b0;
      done_cnt_q   <= '0;
      cmd_rs_q     <= 1'b0;
      cmd_data_q   <= '0;
      en_q         <= 1'b0;
      on_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      init_idx_q   <= init_idx_d;
      init_done_q  <= init_done_d;
      tog_q        <= i_lcd_reg[30];
      pend_valid_q <= pend_valid_d;
      pend_rs_q    <= pend_rs_d;
      pend_data_q  <= pend_data_d;
      ovf_q        <= ovf_d;
      done_cnt_q   <= done_cnt_d;
      cmd_rs_q     <= cmd_rs_d;
      cmd_data_q   <= cmd_data_d;
      en_q         <= (state_d == PULSE);
      on_q         <= i_lcd_reg[31];
      busy_q       <= (state_d != IDLE);
    end
  end

  assign o_lcd_status = {16'h0000, done_cnt_q, 4'h0, ovf_q, init_done_q, pend_valid_q, busy_q};
  assign o_lcd_on     = on_q;
  assign o_lcd_en     = en_q;
  assign o_lcd_rs     = cmd_rs_q;
  assign o_lcd_rw     = 1'b0;
  assign o_lcd_data   = cmd_data_q;

endmodule
